// File: rtl/led_driver_axil_slave_pkg.sv
// Shared definitions for the LED driver AXI4-Lite responder.
//   - Register word offsets (addr[3:2]) for the four 32-bit registers.
//   - Write/read channel FSM state types.
//   - AXI OKAY response code.
//   - apply_wstrb(): byte-lane merge of write data into an existing word.
package led_driver_pkg;

    localparam logic [1:0] REG_LED_VALUE    = 2'd0;
    localparam logic [1:0] REG_BLINK_MASK   = 2'd1;
    localparam logic [1:0] REG_BLINK_PERIOD = 2'd2;
    localparam logic [1:0] REG_SCRATCH      = 2'd3;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} wr_state_t;
    typedef enum logic       {R_IDLE, R_DATA} rd_state_t;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/led_driver_axil_slave_if.sv
// AXI4-Lite bus bundle between the PS/VIP master and the LED driver.
//   master modport: drives AW/W/AR address/data/valid and B/R ready.
//   slave modport : drives AW/W/AR ready, B response and R data/response.
// Parameters: ADDR_W (byte address width), DATA_W (data width, 32).
interface led_driver_axil_slave_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/led_driver_axil_slave_blink_gen.sv
// led_blink_gen: half-period blink phase generator for the LED driver.
// Only built when LED_DRIVER_BLINK_EN is defined.
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   period in  half-period in cycles; 0 freezes the counter and phase
//   clear  in  restart: counter and phase return to 0
//   phase  out current blink phase (registered)
`ifdef LED_DRIVER_BLINK_EN
module led_blink_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] period,
    input  logic        clear,
    output logic        phase
);

    logic [31:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (clear) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (period != 32'd0) begin
            // period only changes together with clear, so cnt never overshoots
            if (cnt == period - 32'd1) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + 32'd1;
            end
        end
    end

endmodule
`endif

// File: rtl/led_driver_axil_slave.sv
// AXI4-Lite responder for the LED driver: four 32-bit read/write registers
// (LED_VALUE, BLINK_MASK, BLINK_PERIOD, SCRATCH) driving NUM_LEDS outputs.
// Optional blink generator enabled by the LED_DRIVER_BLINK_EN macro; without
// it the blink phase is tied low and led_o simply follows LED_VALUE.
// Ports:
//   ACLK     in   clock, rising edge
//   ARESETN  in   asynchronous active-low reset
//   s_axi    slave modport of led_driver_axil_slave_if (AW/W/B/AR/R channels)
//   led_o    out  registered LED drive, NUM_LEDS bits
module led_driver_axil_slave
    import led_driver_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_LEDS           = 8
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    led_driver_axil_slave_if.slave   s_axi,
    output logic [NUM_LEDS-1:0]      led_o
);

    logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];

    wr_state_t                     wr_state;
    logic                          aw_ready_q, w_ready_q, bvalid_q;
    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q;
    logic [31:0]                   wdata_q;
    logic [3:0]                    wstrb_q;
    logic                          aw_hs, w_hs, wr_commit;
    logic [1:0]                    wr_idx;
    logic [31:0]                   wr_data;
    logic [3:0]                    wr_strb;

    rd_state_t                     rd_state;
    logic                          ar_ready_q, rvalid_q;
    logic [31:0]                   rdata_q;

    logic                          phase;
    logic                          unused_ok;

    assign s_axi.awready = aw_ready_q;
    assign s_axi.wready  = w_ready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = AXI_RESP_OKAY;
    assign s_axi.arready = ar_ready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = AXI_RESP_OKAY;

    assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0],
                         s_axi.araddr[1:0], aw_addr_q[1:0]};

    assign aw_hs = s_axi.awvalid & aw_ready_q;
    assign w_hs  = s_axi.wvalid  & w_ready_q;

    // Commit happens on the edge where the second of AW/W is accepted; the
    // half that arrived earlier comes from its holding register.
    always_comb begin
        wr_commit = 1'b0;
        wr_idx    = s_axi.awaddr[3:2];
        wr_data   = s_axi.wdata;
        wr_strb   = s_axi.wstrb;
        case (wr_state)
            W_IDLE:   wr_commit = aw_hs & w_hs;
            W_HAVE_A: begin
                wr_commit = w_hs;
                wr_idx    = aw_addr_q[3:2];
            end
            W_HAVE_D: begin
                wr_commit = aw_hs;
                wr_data   = wdata_q;
                wr_strb   = wstrb_q;
            end
            default:  wr_commit = 1'b0;
        endcase
    end

    // Write channel FSM. READYs are low in reset and rise on the first edge
    // after release (the W_IDLE idle branch).
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_state   <= W_IDLE;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            bvalid_q   <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (aw_hs && w_hs) begin
                        aw_ready_q <= 1'b0;
                        w_ready_q  <= 1'b0;
                        bvalid_q   <= 1'b1;
                        wr_state   <= W_RESP;
                    end else if (aw_hs) begin
                        aw_ready_q <= 1'b0;
                        w_ready_q  <= 1'b1;
                        wr_state   <= W_HAVE_A;
                    end else if (w_hs) begin
                        aw_ready_q <= 1'b1;
                        w_ready_q  <= 1'b0;
                        wr_state   <= W_HAVE_D;
                    end else begin
                        aw_ready_q <= 1'b1;
                        w_ready_q  <= 1'b1;
                    end
                end
                W_HAVE_A: if (w_hs) begin
                    w_ready_q <= 1'b0;
                    bvalid_q  <= 1'b1;
                    wr_state  <= W_RESP;
                end
                W_HAVE_D: if (aw_hs) begin
                    aw_ready_q <= 1'b0;
                    bvalid_q   <= 1'b1;
                    wr_state   <= W_RESP;
                end
                W_RESP: if (s_axi.bready) begin
                    bvalid_q   <= 1'b0;
                    aw_ready_q <= 1'b1;
                    w_ready_q  <= 1'b1;
                    wr_state   <= W_IDLE;
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // Holding registers for whichever write half arrives first.
    always_ff @(posedge ACLK) begin
        if (wr_state == W_IDLE && aw_hs) aw_addr_q <= s_axi.awaddr;
        if (wr_state == W_IDLE && w_hs) begin
            wdata_q <= s_axi.wdata;
            wstrb_q <= s_axi.wstrb;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else if (wr_commit) begin
            regs[wr_idx] <= apply_wstrb(regs[wr_idx], wr_data, wr_strb);
        end
    end

    // Read channel FSM. RDATA is captured from the registers as they stand
    // before any same-edge write commit, so a colliding read sees the old value.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rd_state   <= R_IDLE;
            ar_ready_q <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (s_axi.arvalid && ar_ready_q) begin
                        rdata_q    <= regs[s_axi.araddr[3:2]];
                        rvalid_q   <= 1'b1;
                        ar_ready_q <= 1'b0;
                        rd_state   <= R_DATA;
                    end else begin
                        ar_ready_q <= 1'b1;
                    end
                end
                R_DATA: if (s_axi.rready) begin
                    rvalid_q   <= 1'b0;
                    ar_ready_q <= 1'b1;
                    rd_state   <= R_IDLE;
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

`ifdef LED_DRIVER_BLINK_EN
    led_blink_gen u_blink (
        .clk    (ACLK),
        .rst_n  (ARESETN),
        .period (regs[REG_BLINK_PERIOD]),
        .clear  (wr_commit && (wr_idx == REG_BLINK_PERIOD)),
        .phase  (phase)
    );
`else
    assign phase = 1'b0;
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            led_o <= '0;
        end else begin
            led_o <= regs[REG_LED_VALUE][NUM_LEDS-1:0] ^
                     (regs[REG_BLINK_MASK][NUM_LEDS-1:0] & {NUM_LEDS{phase}});
        end
    end

endmodule
